// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the alu arbiter: FSM states, flag layout, alu op codes.
// Op codes mirror the alu's own decode; anything at or above ALU_NUM_OPS is illegal.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } arb_state_e;

  localparam int FLAG_W  = 4;
  localparam int FLAG_EQ = 3;
  localparam int FLAG_NE = 2;
  localparam int FLAG_LT = 1;
  localparam int FLAG_GT = 0;

  localparam int unsigned ALU_ADD     = 0;
  localparam int unsigned ALU_SUB     = 1;
  localparam int unsigned ALU_AND     = 2;
  localparam int unsigned ALU_OR      = 3;
  localparam int unsigned ALU_XOR     = 4;
  localparam int unsigned ALU_SLT     = 5;
  localparam int unsigned ALU_SLTU    = 6;
  localparam int unsigned ALU_NUM_OPS = 7;

  function automatic logic op_legal(input int unsigned op);
    return op < ALU_NUM_OPS;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches from last+1 upward,
// wrapping, and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = int'((32'(last) + 32'(k)) % 32'(N));
      if (!any && req[c]) begin
        any = 1'b1;
        idx = IW'(c);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between N_REQ requesters with a
// round-robin grant and registered operands, result and flags.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*OP_WIDTH-1:0]   req_op,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]            resp_valid,
  input  logic [N_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]       resp_result,
  output logic [FLAG_W-1:0]           resp_flags,
  output logic [OP_WIDTH-1:0]         alu_op,
  output logic [DATA_WIDTH-1:0]       alu_a,
  output logic [DATA_WIDTH-1:0]       alu_b,
  input  logic [DATA_WIDTH-1:0]       alu_result,
  input  logic                        alu_eq,
  input  logic                        alu_ne,
  input  logic                        alu_lt,
  input  logic                        alu_gt
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e state;

  logic [IW-1:0]         last_q;
  logic [IW-1:0]         gnt_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [N_REQ-1:0]  gnt_oh;
  logic [FLAG_W-1:0] flags_d;
  logic [31:0]       op_ext;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req  (req_valid),
    .last (last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Accept only in IDLE; held low during reset even though state is IDLE.
  assign req_ready = (state == ARB_IDLE && !rst) ? arb_gnt : '0;

  assign alu_op = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  assign gnt_oh = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_q;
  assign op_ext = 32'(op_q);

  always_comb begin
    flags_d          = '0;
    flags_d[FLAG_EQ] = alu_eq;
    flags_d[FLAG_NE] = alu_ne;
    flags_d[FLAG_LT] = alu_lt;
    flags_d[FLAG_GT] = alu_gt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      last_q      <= IW'(N_REQ-1);
      gnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_result <= '0;
      resp_flags  <= '0;
      resp_valid  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (arb_any) begin
            gnt_q <= arb_idx;
            op_q  <= req_op[arb_idx*OP_WIDTH +: OP_WIDTH];
            a_q   <= req_a[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            b_q   <= req_b[arb_idx*DATA_WIDTH +: DATA_WIDTH];
            state <= ARB_EXEC;
          end
        end
        ARB_EXEC: begin
          resp_result <= op_legal(op_ext) ? alu_result : '0;
          resp_flags  <= flags_d;
          resp_valid  <= gnt_oh;
          state       <= ARB_RESP;
        end
        ARB_RESP: begin
          if (resp_ready[gnt_q]) begin
            resp_valid <= '0;
            last_q     <= gnt_q;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
